// File: rtl/int_fp_acc.sv
// Group accumulator behind int_fp_mul: sums a product stream in saturating
// int16 or truncating FP16 and emits one registered result per group.
module int_fp_acc (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_underflow,
    input  logic        in_overflow,
    input  logic        mode,
    input  logic        acc_last,
    input  logic        acc_clear,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_underflow,
    output logic        out_overflow,
    output logic [7:0]  out_count
);

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t      state_reg;
    logic [15:0] acc_reg;
    logic [7:0]  cnt_reg;
    logic        unf_reg;
    logic        ovf_reg;
    logic        grp_mode_reg;

    logic [16:0] int_sum;
    logic [17:0] fp_res;
    logic [15:0] sum_next;
    logic        add_unf;
    logic        add_ovf;
    logic [7:0]  cnt_next;
    logic        unf_next;
    logic        ovf_next;

    // Returns {overflow, underflow, result}. Operands are aligned into a field
    // wide enough for the largest exponent gap, so truncation acts on the exact sum.
    function automatic logic [17:0] fp_add(input logic [15:0] a, input logic [15:0] b);
        logic        a_nan, b_nan, a_inf, b_inf;
        logic        sa, sb, st;
        logic [4:0]  ea, eb, et;
        logic [10:0] ma, mb, mt;
        logic [4:0]  diff;
        logic [40:0] ext_a, ext_b;
        logic [41:0] s;
        int          p;
        int          e;
        logic [17:0] r;
        a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
        sa = a[15];
        sb = b[15];
        ea = a[14:10];
        eb = b[14:10];
        ma = (ea == 5'd0) ? 11'd0 : {1'b1, a[9:0]};
        mb = (eb == 5'd0) ? 11'd0 : {1'b1, b[9:0]};
        if ({eb, mb} > {ea, ma}) begin
            st = sa; et = ea; mt = ma;
            sa = sb; ea = eb; ma = mb;
            sb = st; eb = et; mb = mt;
        end
        diff  = ea - eb;
        ext_a = {ma, 30'd0};
        ext_b = {mb, 30'd0} >> diff;
        if (sa == sb)
            s = {1'b0, ext_a} + {1'b0, ext_b};
        else
            s = {1'b0, ext_a} - {1'b0, ext_b};
        p = 0;
        for (int i = 0; i < 42; i++) begin
            if (s[i])
                p = i;
        end
        e = int'(ea) + p - 40;
        r = 18'd0;
        if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15])))
            r = {2'b00, 16'h7E00};
        else if (a_inf)
            r = {2'b00, a};
        else if (b_inf)
            r = {2'b00, b};
        else if (s == 42'd0)
            r = 18'd0;
        else if (e >= 31)
            r = {2'b10, sa, 5'h1F, 10'd0};
        else if (e <= 0)
            r = {2'b01, sa, 15'd0};
        else
            r = {2'b00, sa, e[4:0], 10'(s >> (p - 10))};
        return r;
    endfunction

    assign int_sum = {acc_reg[15], acc_reg} + {in_data[15], in_data};
    assign fp_res  = fp_add(acc_reg, in_data);

    always_comb begin
        sum_next = int_sum[15:0];
        add_unf  = 1'b0;
        add_ovf  = 1'b0;
        if (grp_mode_reg) begin
            sum_next = fp_res[15:0];
            add_ovf  = fp_res[17];
            add_unf  = fp_res[16];
        end else if (int_sum[16:15] == 2'b01) begin
            sum_next = 16'h7FFF;
            add_ovf  = 1'b1;
        end else if (int_sum[16:15] == 2'b10) begin
            sum_next = 16'h8000;
            add_unf  = 1'b1;
        end
        cnt_next = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
        unf_next = unf_reg | in_underflow | add_unf;
        ovf_next = ovf_reg | in_overflow | add_ovf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            acc_reg       <= 16'd0;
            cnt_reg       <= 8'd0;
            unf_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
            grp_mode_reg  <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= 16'd0;
            out_underflow <= 1'b0;
            out_overflow  <= 1'b0;
            out_count     <= 8'd0;
        end else begin
            out_valid <= 1'b0;
            if (acc_clear) begin
                // Clear outranks any beat in the same cycle, including a last beat.
                state_reg    <= IDLE;
                acc_reg      <= 16'd0;
                cnt_reg      <= 8'd0;
                unf_reg      <= 1'b0;
                ovf_reg      <= 1'b0;
                grp_mode_reg <= 1'b0;
            end else if (in_valid) begin
                case (state_reg)
                    IDLE: begin
                        if (acc_last) begin
                            out_valid     <= 1'b1;
                            out_data      <= in_data;
                            out_count     <= 8'd1;
                            out_underflow <= in_underflow;
                            out_overflow  <= in_overflow;
                        end else begin
                            state_reg    <= ACCUM;
                            grp_mode_reg <= mode;
                            acc_reg      <= in_data;
                            cnt_reg      <= 8'd1;
                            unf_reg      <= in_underflow;
                            ovf_reg      <= in_overflow;
                        end
                    end
                    ACCUM: begin
                        if (acc_last) begin
                            state_reg     <= IDLE;
                            out_valid     <= 1'b1;
                            out_data      <= sum_next;
                            out_count     <= cnt_next;
                            out_underflow <= unf_next;
                            out_overflow  <= ovf_next;
                            acc_reg       <= 16'd0;
                            cnt_reg       <= 8'd0;
                            unf_reg       <= 1'b0;
                            ovf_reg       <= 1'b0;
                        end else begin
                            acc_reg <= sum_next;
                            cnt_reg <= cnt_next;
                            unf_reg <= unf_next;
                            ovf_reg <= ovf_next;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_int_fp_acc.sv
// Directed bench for int_fp_acc: integer, FP16, clear, back-to-back and reset scenarios.
module tb_int_fp_acc;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        in_underflow = 1'b0;
    logic        in_overflow = 1'b0;
    logic        mode = 1'b0;
    logic        acc_last = 1'b0;
    logic        acc_clear = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_underflow;
    logic        out_overflow;
    logic [7:0]  out_count;

    int errors = 0;
    int checks = 0;

    int_fp_acc dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_underflow(in_underflow), .in_overflow(in_overflow), .mode(mode),
        .acc_last(acc_last), .acc_clear(acc_clear), .out_valid(out_valid),
        .out_data(out_data), .out_underflow(out_underflow),
        .out_overflow(out_overflow), .out_count(out_count)
    );

    always #5 clk = ~clk;

    // One beat per call; returns #1 after the sampling edge with inputs idle again.
    task automatic beat(input logic [15:0] d, input logic last, input logic m,
                        input logic uf, input logic of, input logic clr);
        in_valid = 1'b1; in_data = d; acc_last = last; mode = m;
        in_underflow = uf; in_overflow = of; acc_clear = clr;
        @(posedge clk); #1;
        in_valid = 1'b0; acc_last = 1'b0; acc_clear = 1'b0;
        in_underflow = 1'b0; in_overflow = 1'b0;
        $display("beat d=%h last=%0d mode=%0d clr=%0d -> out_valid=%0d out_data=%h count=%0d uf=%0d of=%0d",
                 d, last, m, clr, out_valid, out_data, out_count, out_underflow, out_overflow);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_cycle(); idle_cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset data: got %h expected 0000", out_data); end
        checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL reset count: got %0d expected 0", out_count); end
        checks++; if ({out_underflow, out_overflow} !== 2'b00) begin errors++; $display("FAIL reset flags: got %b expected 00", {out_underflow, out_overflow}); end
        reset = 1'b0;
        idle_cycle();
    endtask

    task automatic test_int_sum();
        beat(16'h0003, 0, 0, 0, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL int_sum early valid: got %b expected 0", out_valid); end
        beat(16'h0005, 0, 0, 0, 0, 0);
        beat(16'hFFFE, 1, 0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL int_sum valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 16'h0006) begin errors++; $display("FAIL int_sum data: got %h expected 0006", out_data); end
        checks++; if (out_count !== 8'd3) begin errors++; $display("FAIL int_sum count: got %0d expected 3", out_count); end
        checks++; if ({out_underflow, out_overflow} !== 2'b00) begin errors++; $display("FAIL int_sum flags: got %b expected 00", {out_underflow, out_overflow}); end
        idle_cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL int_sum pulse width: got %b expected 0", out_valid); end
        checks++; if (out_data !== 16'h0006) begin errors++; $display("FAIL int_sum hold: got %h expected 0006", out_data); end
    endtask

    task automatic test_int_sat();
        beat(16'h7000, 0, 0, 0, 0, 0);
        beat(16'h2000, 1, 0, 0, 0, 0);
        checks++; if (out_data !== 16'h7FFF) begin errors++; $display("FAIL int_ovf data: got %h expected 7fff", out_data); end
        checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL int_ovf flag: got %b expected 1", out_overflow); end
        beat(16'h0001, 0, 0, 1, 0, 0);
        beat(16'h0001, 1, 0, 0, 0, 0);
        checks++; if (out_data !== 16'h0002) begin errors++; $display("FAIL sticky data: got %h expected 0002", out_data); end
        checks++; if ({out_underflow, out_overflow} !== 2'b10) begin errors++; $display("FAIL sticky flags: got %b expected 10", {out_underflow, out_overflow}); end
        beat(16'h8000, 0, 0, 0, 0, 0);
        beat(16'hFFFF, 1, 0, 0, 0, 0);
        checks++; if (out_data !== 16'h8000) begin errors++; $display("FAIL int_unf data: got %h expected 8000", out_data); end
        checks++; if ({out_underflow, out_overflow} !== 2'b10) begin errors++; $display("FAIL int_unf flags: got %b expected 10", {out_underflow, out_overflow}); end
    endtask

    task automatic test_fp();
        logic [15:0] fa [9] = '{16'h3C00, 16'h3C00, 16'h7BFF, 16'h7C00, 16'h0401, 16'h3C00, 16'h3C00, 16'h3C00, 16'h7C00};
        logic [15:0] fb [9] = '{16'h4000, 16'hBC00, 16'h7BFF, 16'hFC00, 16'h8400, 16'h1BFF, 16'h9BFF, 16'h7D00, 16'h3C00};
        logic [15:0] fr [9] = '{16'h4200, 16'h0000, 16'h7C00, 16'h7E00, 16'h0000, 16'h3C03, 16'h3BF8, 16'h7E00, 16'h7C00};
        logic        fo [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        fu [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            beat(fa[i], 0, 1, 0, 0, 0);
            beat(fb[i], 1, 1, 0, 0, 0);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fp[%0d] valid: got %b expected 1", i, out_valid); end
            checks++; if (out_data !== fr[i]) begin errors++; $display("FAIL fp[%0d] data: got %h expected %h", i, out_data, fr[i]); end
            checks++; if (out_overflow !== fo[i]) begin errors++; $display("FAIL fp[%0d] ovf: got %b expected %b", i, out_overflow, fo[i]); end
            checks++; if (out_underflow !== fu[i]) begin errors++; $display("FAIL fp[%0d] unf: got %b expected %b", i, out_underflow, fu[i]); end
            checks++; if (out_count !== 8'd2) begin errors++; $display("FAIL fp[%0d] count: got %0d expected 2", i, out_count); end
        end
    endtask

    task automatic test_clear();
        beat(16'h0004, 0, 0, 0, 0, 0);
        beat(16'h0009, 0, 0, 0, 0, 1);
        beat(16'h0001, 1, 0, 0, 0, 0);
        checks++; if (out_data !== 16'h0001) begin errors++; $display("FAIL clear data: got %h expected 0001", out_data); end
        checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL clear count: got %0d expected 1", out_count); end
        beat(16'h0005, 0, 0, 0, 0, 0);
        beat(16'h0007, 1, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_last valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 16'h0001) begin errors++; $display("FAIL clear_last hold: got %h expected 0001", out_data); end
        idle_cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_last late valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        beat(16'h1234, 1, 0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b first valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 16'h1234) begin errors++; $display("FAIL b2b first data: got %h expected 1234", out_data); end
        beat(16'h3C00, 0, 1, 0, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b gap valid: got %b expected 0", out_valid); end
        beat(16'h3C00, 1, 0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b second valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 16'h4000) begin errors++; $display("FAIL b2b mode latch data: got %h expected 4000", out_data); end
        checks++; if (out_count !== 8'd2) begin errors++; $display("FAIL b2b count: got %0d expected 2", out_count); end
    endtask

    task automatic test_count_sat();
        for (int i = 0; i < 259; i++)
            beat(16'h0000, 0, 0, 0, 0, 0);
        beat(16'h0000, 1, 0, 0, 0, 0);
        checks++; if (out_count !== 8'd255) begin errors++; $display("FAIL count_sat: got %0d expected 255", out_count); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL count_sat data: got %h expected 0000", out_data); end
    endtask

    task automatic test_reset_mid();
        beat(16'h0005, 0, 0, 0, 1, 0);
        beat(16'h0006, 0, 0, 0, 0, 0);
        reset = 1'b1;
        idle_cycle();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rst_mid data: got %h expected 0000", out_data); end
        checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL rst_mid count: got %0d expected 0", out_count); end
        beat(16'h0002, 1, 0, 0, 0, 0);
        checks++; if (out_data !== 16'h0002) begin errors++; $display("FAIL rst_mid after data: got %h expected 0002", out_data); end
        checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL rst_mid after count: got %0d expected 1", out_count); end
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL rst_mid after ovf: got %b expected 0", out_overflow); end
    endtask

    initial begin
        test_reset();
        test_int_sum();
        test_int_sat();
        test_fp();
        test_clear();
        test_back_to_back();
        test_count_sat();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
